keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad and delivers debounced key-press events over a valid/ready handshake. It is the input-side counterpart of the multiplexed seven-segment driver. Where that driver strobes one anode per slot and drives cathodes, this block strobes one keypad row per slot and samples the column lines. It sits between board pins and the processor-side peripheral register logic.

---
 rtl/keypad_scanner_pkg.sv | 36 +++
 rtl/keypad_scanner_if.sv | 27 ++
 rtl/keypad_scanner_col_synchronizer.sv | 24 ++
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// A frame result is a kind plus the key code, which is meaningful only for a single key.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } res_kind_e;

    typedef struct packed {
        res_kind_e         kind;
        logic [CODE_W-1:0] code;
    } frame_res_t;

    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } dbn_state_e;

    localparam frame_res_t RES_IDLE = '{kind: RES_NONE, code: '0};

    function automatic logic [2:0] count_low(input logic [NUM_COLS-1:0] low);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            n = n + {2'b00, low[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event handshake between the scanner (master) and the register-side consumer (slave).
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;
    logic              key_down;
    logic              key_overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_down,
        output key_overrun,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_down,
        input  key_overrun,
        output key_ready
    );

endinterface

// File: rtl/keypad_scanner_col_synchronizer.sv
// Two-flop synchronizer for the asynchronous column returns.
// Resets to all-ones so an idle keypad (pull-ups) reads as no key pressed.
module col_synchronizer
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] cols,
    output logic [NUM_COLS-1:0] cols_sync
);

    logic [NUM_COLS-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta      <= '1;
            cols_sync <= '1;
        end else begin
            meta      <= cols;
            cols_sync <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row strobing, frame classification, debounce and
// a one-entry key event register behind a valid/ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | debounced state is NONE, no key held
//   ST_HELD | debounced state is a single key (stable_code)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 250000,
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_ROWS-1:0] rows,
    input  logic [NUM_COLS-1:0] cols,
    keypad_scanner_if.master    key
);

    localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DBN_TC    = 4'(DEBOUNCE);

    logic [NUM_COLS-1:0] cols_sync;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [1:0]          row_idx;
    logic                slot_end;
    logic                frame_end;

    logic [1:0]          acc_cnt;
    logic [CODE_W-1:0]   acc_code;
    logic [1:0]          acc_cnt_nxt;
    logic [CODE_W-1:0]   acc_code_nxt;
    logic [NUM_COLS-1:0] low;
    logic [2:0]          low_cnt;
    logic [1:0]          col_idx;
    frame_res_t          cur_res;

    frame_res_t          prev_res;
    frame_res_t          prev_nxt;
    logic [3:0]          match_cnt;
    logic [3:0]          match_nxt;
    logic                accept;

    dbn_state_e          state;
    dbn_state_e          state_nxt;
    logic [CODE_W-1:0]   stable_code;
    logic [CODE_W-1:0]   stable_nxt;
    logic                press_evt;

    col_synchronizer u_sync (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .cols_sync (cols_sync)
    );

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (row_idx == 2'd3);
    assign rows      = ~(NUM_ROWS'(1) << row_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            row_idx  <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            row_idx  <= row_idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Accumulator only needs to distinguish 0, 1 and "2 or more" low bits per frame.
    always_comb begin
        low     = ~cols_sync;
        low_cnt = count_low(low);
        col_idx = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (low[i]) col_idx = 2'(i);
        end

        acc_cnt_nxt  = acc_cnt;
        acc_code_nxt = acc_code;
        if (acc_cnt == 2'd2 || low_cnt >= 3'd2 || (acc_cnt == 2'd1 && low_cnt == 3'd1)) begin
            acc_cnt_nxt = 2'd2;
        end else if (low_cnt == 3'd1) begin
            acc_cnt_nxt  = 2'd1;
            acc_code_nxt = {row_idx, col_idx};
        end

        cur_res = RES_IDLE;
        if (acc_cnt_nxt == 2'd1) begin
            cur_res.kind = RES_SINGLE;
            cur_res.code = acc_code_nxt;
        end else if (acc_cnt_nxt == 2'd2) begin
            cur_res.kind = RES_MULTI;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt  <= '0;
            acc_code <= '0;
        end else if (frame_end) begin
            acc_cnt  <= '0;
            acc_code <= '0;
        end else if (slot_end) begin
            acc_cnt  <= acc_cnt_nxt;
            acc_code <= acc_code_nxt;
        end
    end

    always_comb begin
        prev_nxt  = prev_res;
        match_nxt = match_cnt;
        if (frame_end) begin
            prev_nxt = cur_res;
            if (cur_res.kind == RES_MULTI) begin
                match_nxt = '0;
            end else if (cur_res == prev_res) begin
                match_nxt = (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;
            end else begin
                match_nxt = 4'd1;
            end
        end
        accept = frame_end && (cur_res.kind != RES_MULTI) && (match_nxt >= DBN_TC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_res    <= RES_IDLE;
            match_cnt   <= '0;
            state       <= ST_IDLE;
            stable_code <= '0;
        end else begin
            prev_res    <= prev_nxt;
            match_cnt   <= match_nxt;
            state       <= state_nxt;
            stable_code <= stable_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stable_nxt = stable_code;
        press_evt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && cur_res.kind == RES_SINGLE) begin
                    state_nxt  = ST_HELD;
                    stable_nxt = cur_res.code;
                    press_evt  = 1'b1;
                end
            end
            ST_HELD: begin
                if (accept && cur_res.kind == RES_NONE) begin
                    state_nxt = ST_IDLE;
                end else if (accept && cur_res.code != stable_code) begin
                    stable_nxt = cur_res.code;
                    press_evt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign key.key_down = (state == ST_HELD);

    // A handshake in the event cycle frees the slot, so the new event is not an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            key.key_code    <= '0;
            key.key_valid   <= 1'b0;
            key.key_overrun <= 1'b0;
        end else begin
            key.key_overrun <= 1'b0;
            if (press_evt && (!key.key_valid || key.key_ready)) begin
                key.key_code  <= stable_nxt;
                key.key_valid <= 1'b1;
            end else if (press_evt) begin
                key.key_overrun <= 1'b1;
            end else if (key.key_valid && key.key_ready) begin
                key.key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frame)
// and a behavioural 4x4 switch matrix driving the column lines.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [15:0] pressed;
    int          cyc;
    int          ovr_cnt;
    int          n_pass;
    int          n_total;
    int          viol;

    keypad_scanner_if key_if ();

    keypad_scanner #(
        .SCAN_DIV (4),
        .DEBOUNCE (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rows  (rows),
        .cols  (cols),
        .key   (key_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key index r*4+c shorts row r to column c.
    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
        if (key_if.key_overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align_frame();
        for (int i = 0; i < 16 && (cyc % 16) != 0; i++) step(1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rows"},    32'(rows), 32'h0000000E);
        check({tag, "_valid"},   32'(key_if.key_valid), 32'd0);
        check({tag, "_code"},    32'(key_if.key_code), 32'd0);
        check({tag, "_down"},    32'(key_if.key_down), 32'd0);
        check({tag, "_overrun"}, 32'(key_if.key_overrun), 32'd0);
    endtask

    initial begin
        n_pass           = 0;
        n_total          = 0;
        ovr_cnt          = 0;
        reset            = 1'b1;
        pressed          = '0;
        key_if.key_ready = 1'b0;
        step(3);
        check_reset_state("reset");
        reset = 1'b0;

        // Idle: 10 frames of row strobing, nothing pressed.
        viol = 0;
        for (int i = 1; i <= 160; i++) begin
            logic [3:0] exp_rows;
            step(1);
            exp_rows = ~(4'b0001 << ((i / 4) % 4));
            check("idle_rows", 32'(rows), 32'(exp_rows));
            if (key_if.key_valid || key_if.key_down) viol++;
        end
        check("idle_quiet", 32'(viol), 32'd0);

        // Clean press of row 2 / col 1 with key_ready held high.
        key_if.key_ready = 1'b1;
        align_frame();
        pressed[9] = 1'b1;
        viol = 0;
        for (int i = 0; i < 47; i++) begin
            step(1);
            if (key_if.key_valid) viol++;
        end
        check("press_early", 32'(viol), 32'd0);
        step(1);
        check("press_valid", 32'(key_if.key_valid), 32'd1);
        check("press_code",  32'(key_if.key_code), 32'h9);
        check("press_down",  32'(key_if.key_down), 32'd1);
        step(1);
        check("press_hs_valid", 32'(key_if.key_valid), 32'd0);
        check("press_hs_code",  32'(key_if.key_code), 32'h9);

        align_frame();
        pressed[9] = 1'b0;
        viol = 0;
        for (int i = 0; i < 47; i++) begin
            step(1);
            if (key_if.key_valid || !key_if.key_down) viol++;
        end
        check("release_hold", 32'(viol), 32'd0);
        step(1);
        check("release_down", 32'(key_if.key_down), 32'd0);

        // Bounce: contact toggles every 10 cycles for 8 frames, then held closed.
        align_frame();
        step(6);
        viol = 0;
        for (int k = 0; k < 170; k++) begin
            pressed[9] = (k < 128) ? (((k / 10) % 2) == 0) : 1'b1;
            step(1);
            if (k < 169 && key_if.key_valid) viol++;
        end
        check("bounce_quiet", 32'(viol), 32'd0);
        check("bounce_valid", 32'(key_if.key_valid), 32'd1);
        check("bounce_code",  32'(key_if.key_code), 32'h9);
        step(1);
        check("bounce_hs_valid", 32'(key_if.key_valid), 32'd0);
        align_frame();
        pressed = '0;
        step(64);
        check("bounce_release_down", 32'(key_if.key_down), 32'd0);

        // Multi-key: 0 and 5 together are ignored, releasing 5 yields key 0.
        align_frame();
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        viol = 0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (key_if.key_valid || key_if.key_down) viol++;
        end
        check("multi_quiet", 32'(viol), 32'd0);
        pressed[5] = 1'b0;
        viol = 0;
        for (int i = 0; i < 47; i++) begin
            step(1);
            if (key_if.key_valid) viol++;
        end
        check("multi_early", 32'(viol), 32'd0);
        step(1);
        check("multi_valid", 32'(key_if.key_valid), 32'd1);
        check("multi_code",  32'(key_if.key_code), 32'h0);
        check("multi_down",  32'(key_if.key_down), 32'd1);
        step(1);
        align_frame();
        pressed = '0;
        step(64);
        check("multi_release_down", 32'(key_if.key_down), 32'd0);

        // Backpressure: 3 is held in the register, the later C event is dropped.
        key_if.key_ready = 1'b0;
        align_frame();
        pressed[3] = 1'b1;
        step(48);
        check("bp_valid", 32'(key_if.key_valid), 32'd1);
        check("bp_code",  32'(key_if.key_code), 32'h3);
        pressed[3] = 1'b0;
        step(48);
        check("bp_release_down",  32'(key_if.key_down), 32'd0);
        check("bp_release_valid", 32'(key_if.key_valid), 32'd1);
        pressed[12] = 1'b1;
        step(47);
        check("bp_no_overrun_yet", 32'(ovr_cnt), 32'd0);
        step(1);
        check("bp_overrun",     32'(key_if.key_overrun), 32'd1);
        check("bp_keep_valid",  32'(key_if.key_valid), 32'd1);
        check("bp_keep_code",   32'(key_if.key_code), 32'h3);
        check("bp_down_c",      32'(key_if.key_down), 32'd1);
        step(1);
        check("bp_overrun_end", 32'(key_if.key_overrun), 32'd0);
        check("bp_overrun_cnt", 32'(ovr_cnt), 32'd1);
        key_if.key_ready = 1'b1;
        step(1);
        check("bp_drain_valid", 32'(key_if.key_valid), 32'd0);
        check("bp_drain_code",  32'(key_if.key_code), 32'h3);

        // Reset in frame 2 of the debounce of key 7 restarts the debounce.
        align_frame();
        pressed = '0;
        step(64);
        align_frame();
        pressed[7] = 1'b1;
        viol = 0;
        for (int i = 0; i < 21; i++) begin
            step(1);
            if (key_if.key_valid) viol++;
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_reset_state("midreset");
        for (int i = 0; i < 47; i++) begin
            step(1);
            if (key_if.key_valid) viol++;
        end
        check("midreset_early", 32'(viol), 32'd0);
        step(1);
        check("midreset_valid", 32'(key_if.key_valid), 32'd1);
        check("midreset_code",  32'(key_if.key_code), 32'h7);
        check("midreset_down",  32'(key_if.key_down), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
